// File: rtl/mem_stage_hs.sv
// Memory-access stage: waits for data_ok, buffers the response while WB stalls, aligns and extends load data.
// Latency: one cycle from accept. Load data may bypass combinationally when data_ok arrives in the first MEM cycle.
// Backpressure: ms_allowin drops while a request is outstanding or WB stalls. Stale responses after a flush are counted and dropped.
module mem_stage_hs #(
    parameter int PASS_W  = 64,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ws_allowin,
    output logic              ms_allowin,
    input  logic              es_to_ms_valid,
    input  logic              es_mem_req,
    input  logic              es_load,
    input  logic [1:0]        es_size,
    input  logic              es_s_ext,
    input  logic              es_left,
    input  logic              es_right,
    input  logic [1:0]        es_addr_low,
    input  logic [31:0]       es_rt_value,
    input  logic [31:0]       es_alu_result,
    input  logic [PASS_W-1:0] es_pass,
    input  logic              es_inflight_flushed,
    input  logic              ms_flush,
    input  logic              data_sram_data_ok,
    input  logic [31:0]       data_sram_rdata,
    output logic              ms_to_ws_valid,
    output logic [31:0]       ms_result,
    output logic [PASS_W-1:0] ms_pass,
    output logic              ms_fwd_valid,
    output logic              ms_fwd_block
);
    localparam int CNT_W = $clog2(MAX_OUT + 1);

    logic              ms_valid;
    logic              ms_wait;
    logic              buf_valid;
    logic [31:0]       buf_data;
    logic [CNT_W-1:0]  discard_cnt;
    logic              load_r, s_ext_r, left_r, right_r;
    logic [1:0]        size_r, addr_r;
    logic [31:0]       rt_r, alu_r;
    logic [PASS_W-1:0] pass_r;

    logic drop, take, ms_ready_go, accept, leave;
    logic [CNT_W:0] cnt_next;
    logic [31:0] d, aligned;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign drop           = data_sram_data_ok && (discard_cnt != '0);
    assign take           = data_sram_data_ok && !drop && ms_valid && ms_wait;
    assign ms_ready_go    = !ms_wait || take;
    assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid && ms_ready_go && !ms_flush;
    assign leave          = ms_to_ws_valid && ws_allowin;
    assign accept         = es_to_ms_valid && ms_allowin && !ms_flush;
    assign ms_fwd_valid   = ms_valid && ms_ready_go;
    assign ms_fwd_block   = ms_valid && load_r && !ms_ready_go;
    assign ms_pass        = pass_r;

    // A flushed instruction still waiting on the bus leaves one stale response behind.
    assign cnt_next = {1'b0, discard_cnt}
                    + {{CNT_W{1'b0}}, ms_flush && ms_valid && ms_wait && !take}
                    + {{CNT_W{1'b0}}, ms_flush && es_inflight_flushed}
                    - {{CNT_W{1'b0}}, drop};

    always_comb begin
        d        = buf_valid ? buf_data : data_sram_rdata;
        byte_sel = d[7:0];
        case (addr_r)
            2'd1:    byte_sel = d[15:8];
            2'd2:    byte_sel = d[23:16];
            2'd3:    byte_sel = d[31:24];
            default: byte_sel = d[7:0];
        endcase
        half_sel = addr_r[1] ? d[31:16] : d[15:0];
        aligned  = d;
        if (left_r) begin
            case (addr_r)
                2'd0:    aligned = {d[7:0],  rt_r[23:0]};
                2'd1:    aligned = {d[15:0], rt_r[15:0]};
                2'd2:    aligned = {d[23:0], rt_r[7:0]};
                default: aligned = d;
            endcase
        end else if (right_r) begin
            case (addr_r)
                2'd3:    aligned = {rt_r[31:8],  d[31:24]};
                2'd2:    aligned = {rt_r[31:16], d[31:16]};
                2'd1:    aligned = {rt_r[31:24], d[31:8]};
                default: aligned = d;
            endcase
        end else begin
            case (size_r)
                2'd0:    aligned = {{24{s_ext_r & byte_sel[7]}}, byte_sel};
                2'd1:    aligned = {{16{s_ext_r & half_sel[15]}}, half_sel};
                default: aligned = d;
            endcase
        end
        ms_result = load_r ? aligned : alu_r;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid    <= 1'b0;
            ms_wait     <= 1'b0;
            buf_valid   <= 1'b0;
            buf_data    <= '0;
            discard_cnt <= '0;
            load_r      <= 1'b0;
            s_ext_r     <= 1'b0;
            left_r      <= 1'b0;
            right_r     <= 1'b0;
            size_r      <= '0;
            addr_r      <= '0;
            rt_r        <= '0;
            alu_r       <= '0;
            pass_r      <= '0;
        end else begin
            discard_cnt <= cnt_next[CNT_W-1:0];
            if (ms_flush) begin
                ms_valid  <= 1'b0;
                ms_wait   <= 1'b0;
                buf_valid <= 1'b0;
            end else begin
                if (ms_allowin)
                    ms_valid <= es_to_ms_valid;
                if (accept) begin
                    ms_wait   <= es_mem_req;
                    buf_valid <= 1'b0;
                    load_r    <= es_load;
                    s_ext_r   <= es_s_ext;
                    left_r    <= es_left;
                    right_r   <= es_right;
                    size_r    <= es_size;
                    addr_r    <= es_addr_low;
                    rt_r      <= es_rt_value;
                    alu_r     <= es_alu_result;
                    pass_r    <= es_pass;
                end else if (take) begin
                    ms_wait <= 1'b0;
                    if (!leave) begin
                        buf_valid <= 1'b1;
                        buf_data  <= data_sram_rdata;
                    end
                end
            end
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(data_sram_data_ok && !drop && ms_valid && buf_valid))
                else $error("data_ok received while response already buffered");
            assert (cnt_next <= (CNT_W+1)'(MAX_OUT))
                else $error("discard_cnt exceeds MAX_OUT");
        end
    end
`endif
endmodule

// File: tb/tb_mem_stage_hs.sv
// Directed bench for mem_stage_hs with hand-computed expected values.
module tb_mem_stage_hs;
    logic        clk = 1'b0;
    logic        reset, ws_allowin, ms_allowin, es_to_ms_valid, es_mem_req, es_load;
    logic [1:0]  es_size, es_addr_low;
    logic        es_s_ext, es_left, es_right, es_inflight_flushed, ms_flush;
    logic        data_sram_data_ok, ms_to_ws_valid, ms_fwd_valid, ms_fwd_block;
    logic [31:0] es_rt_value, es_alu_result, data_sram_rdata, ms_result;
    logic [63:0] es_pass, ms_pass;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_stage_hs #(.PASS_W(64), .MAX_OUT(2)) dut (
        .clk(clk), .reset(reset), .ws_allowin(ws_allowin), .ms_allowin(ms_allowin),
        .es_to_ms_valid(es_to_ms_valid), .es_mem_req(es_mem_req), .es_load(es_load),
        .es_size(es_size), .es_s_ext(es_s_ext), .es_left(es_left), .es_right(es_right),
        .es_addr_low(es_addr_low), .es_rt_value(es_rt_value), .es_alu_result(es_alu_result),
        .es_pass(es_pass), .es_inflight_flushed(es_inflight_flushed), .ms_flush(ms_flush),
        .data_sram_data_ok(data_sram_data_ok), .data_sram_rdata(data_sram_rdata),
        .ms_to_ws_valid(ms_to_ws_valid), .ms_result(ms_result), .ms_pass(ms_pass),
        .ms_fwd_valid(ms_fwd_valid), .ms_fwd_block(ms_fwd_block)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        ws_allowin = 1'b1; es_to_ms_valid = 1'b0; es_mem_req = 1'b0; es_load = 1'b0;
        es_size = 2'd2; es_s_ext = 1'b0; es_left = 1'b0; es_right = 1'b0;
        es_addr_low = 2'd0; es_rt_value = '0; es_alu_result = '0; es_pass = '0;
        es_inflight_flushed = 1'b0; ms_flush = 1'b0; data_sram_data_ok = 1'b0;
        data_sram_rdata = '0;
    endtask

    task automatic issue_load(input logic [1:0] sz, input logic sx, input logic l, input logic r,
                              input logic [1:0] a, input logic [31:0] rt);
        es_to_ms_valid = 1'b1; es_mem_req = 1'b1; es_load = 1'b1; es_size = sz;
        es_s_ext = sx; es_left = l; es_right = r; es_addr_low = a; es_rt_value = rt;
        tick;
        es_to_ms_valid = 1'b0;
    endtask

    // Load with data_ok in its first MEM cycle and WB ready.
    task automatic do_load(input string tag, input logic [1:0] sz, input logic sx, input logic l,
                           input logic r, input logic [1:0] a, input logic [31:0] rt,
                           input logic [31:0] rd, input logic [31:0] exp);
        issue_load(sz, sx, l, r, a, rt);
        data_sram_data_ok = 1'b1; data_sram_rdata = rd;
        #2;
        chk({tag, "_vld"}, 32'(ms_to_ws_valid), 32'd1);
        chk(tag, ms_result, exp);
        tick;
        data_sram_data_ok = 1'b0;
        #2;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        tick; tick;
        reset = 1'b0;
        #2;
        chk("rst_to_ws_vld", 32'(ms_to_ws_valid), 32'd0);
        chk("rst_fwd_vld",   32'(ms_fwd_valid),   32'd0);
        chk("rst_fwd_blk",   32'(ms_fwd_block),   32'd0);
        chk("rst_allowin",   32'(ms_allowin),     32'd1);

        // Word load, best case, plus sideband and forward flags.
        tick;
        es_pass = 64'h0123_4567_89ab_cdef;
        es_alu_result = 32'hdead_0000;
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        #2;
        chk("lw_block", 32'(ms_fwd_block), 32'd1);
        chk("lw_wait_vld", 32'(ms_to_ws_valid), 32'd0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h8bad_f00d;
        #2;
        chk("lw_vld", 32'(ms_to_ws_valid), 32'd1);
        chk("lw_res", ms_result, 32'h8bad_f00d);
        chk("lw_fwd", 32'(ms_fwd_valid), 32'd1);
        chk("lw_pass", ms_pass[31:0], 32'h89ab_cdef);
        tick;
        data_sram_data_ok = 1'b0;
        #2;
        chk("lw_gone", 32'(ms_to_ws_valid), 32'd0);

        // LB signed with WB stalled: value held from the buffer.
        issue_load(2'd0, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0080_0000; ws_allowin = 1'b0;
        #2;
        chk("lb_res0", ms_result, 32'hffff_ff80);
        chk("lb_allowin0", 32'(ms_allowin), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick;
            data_sram_data_ok = 1'b0; data_sram_rdata = 32'h0;
            #2;
            chk("lb_hold_vld", 32'(ms_to_ws_valid), 32'd1);
            chk("lb_hold_res", ms_result, 32'hffff_ff80);
        end
        tick;
        ws_allowin = 1'b1;
        #2;
        chk("lb_go_res", ms_result, 32'hffff_ff80);
        chk("lb_go_allowin", 32'(ms_allowin), 32'd1);
        tick;
        #2;
        chk("lb_gone", 32'(ms_to_ws_valid), 32'd0);

        do_load("lwl", 2'd2, 1'b0, 1'b1, 1'b0, 2'd1, 32'h1122_3344, 32'haabb_ccdd, 32'hccdd_3344);
        do_load("lwr", 2'd2, 1'b0, 1'b0, 1'b1, 2'd2, 32'h1122_3344, 32'haabb_ccdd, 32'h1122_aabb);
        do_load("lhu", 2'd1, 1'b0, 1'b0, 1'b0, 2'd2, 32'h0, 32'h8001_0000, 32'h0000_8001);
        do_load("lh",  2'd1, 1'b1, 1'b0, 1'b0, 2'd2, 32'h0, 32'h8001_0000, 32'hffff_8001);
        do_load("lbu", 2'd0, 1'b0, 1'b0, 1'b0, 2'd3, 32'h0, 32'h9a00_0000, 32'h0000_009a);

        // Non-memory instruction: ready immediately; flush suppresses the transfer.
        es_to_ms_valid = 1'b1; es_mem_req = 1'b0; es_load = 1'b0; es_alu_result = 32'h1234_5678;
        ws_allowin = 1'b0;
        tick;
        es_to_ms_valid = 1'b0;
        #2;
        chk("alu_vld", 32'(ms_to_ws_valid), 32'd1);
        chk("alu_res", ms_result, 32'h1234_5678);
        ms_flush = 1'b1;
        #2;
        chk("alu_flush_vld", 32'(ms_to_ws_valid), 32'd0);
        tick;
        ms_flush = 1'b0; ws_allowin = 1'b1;
        #2;
        chk("alu_flushed", 32'(ms_fwd_valid), 32'd0);

        // Flush a waiting load plus one EXE in-flight request: two stale responses.
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        ms_flush = 1'b1; es_inflight_flushed = 1'b1;
        tick;
        ms_flush = 1'b0; es_inflight_flushed = 1'b0;
        #2;
        chk("fl_cnt2", 32'(dut.discard_cnt), 32'd2);
        chk("fl_allowin", 32'(ms_allowin), 32'd1);
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h1111_1111;
        #2;
        chk("drop1_vld", 32'(ms_to_ws_valid), 32'd0);
        chk("drop1_blk", 32'(ms_fwd_block), 32'd1);
        tick;
        data_sram_rdata = 32'h2222_2222;
        #2;
        chk("drop2_cnt", 32'(dut.discard_cnt), 32'd1);
        chk("drop2_vld", 32'(ms_to_ws_valid), 32'd0);
        tick;
        data_sram_rdata = 32'h3333_3333;
        #2;
        chk("third_vld", 32'(ms_to_ws_valid), 32'd1);
        chk("third_res", ms_result, 32'h3333_3333);
        tick;
        data_sram_data_ok = 1'b0;
        #2;

        // Flush coinciding with a dropped data_ok while MEM waits: 1 + 1 - 1.
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        ms_flush = 1'b1;
        tick;
        ms_flush = 1'b0;
        #2;
        chk("cnt1", 32'(dut.discard_cnt), 32'd1);
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        ms_flush = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h4444_4444;
        #2;
        chk("flok_vld", 32'(ms_to_ws_valid), 32'd0);
        tick;
        ms_flush = 1'b0; data_sram_data_ok = 1'b0;
        #2;
        chk("flok_cnt", 32'(dut.discard_cnt), 32'd1);
        chk("flok_gone", 32'(ms_fwd_valid), 32'd0);
        data_sram_data_ok = 1'b1;
        tick;
        data_sram_data_ok = 1'b0;
        #2;
        chk("drain_cnt", 32'(dut.discard_cnt), 32'd0);

        // Reset with a buffered response.
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555; ws_allowin = 1'b0;
        tick;
        data_sram_data_ok = 1'b0;
        #2;
        chk("pre_rst_buf", 32'(dut.buf_valid), 32'd1);
        reset = 1'b1;
        tick;
        reset = 1'b0; ws_allowin = 1'b1;
        #2;
        chk("rst2_vld", 32'(ms_to_ws_valid), 32'd0);
        chk("rst2_allowin", 32'(ms_allowin), 32'd1);
        chk("rst2_buf", 32'(dut.buf_valid), 32'd0);

        // Reset with discard_cnt = 2: next response must not be dropped.
        issue_load(2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0);
        ms_flush = 1'b1; es_inflight_flushed = 1'b1;
        tick;
        ms_flush = 1'b0; es_inflight_flushed = 1'b0;
        #2;
        chk("pre_rst_cnt", 32'(dut.discard_cnt), 32'd2);
        reset = 1'b1;
        tick;
        reset = 1'b0;
        #2;
        chk("rst3_cnt", 32'(dut.discard_cnt), 32'd0);
        chk("rst3_allowin", 32'(ms_allowin), 32'd1);
        do_load("post_rst", 2'd2, 1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0bad_c0de, 32'h0bad_c0de);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
